// File: rtl/hash_arbiter_pkg.sv
// hash_arbiter_pkg
//   Shared definitions for the hash arbiter: FSM state encoding and the
//   width of one hash data word. No ports.
package hash_arbiter_pkg;

    localparam int HASH_W = 32;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

endpackage

// File: rtl/hash_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin first-set finder. Starting at ptr_i and
//   wrapping around, returns the index of the first set bit of pending_i.
//   Ports:
//     pending_i  in  N_REQ  request vector
//     ptr_i      in  REQ_W  highest-priority position (must be < N_REQ)
//     idx_o      out REQ_W  selected index (0 when nothing is pending)
//     valid_o    out 1      at least one bit of pending_i is set
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int REQ_W = 1
) (
    input  logic [N_REQ-1:0] pending_i,
    input  logic [REQ_W-1:0] ptr_i,
    output logic [REQ_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the farthest offset down to offset 0 so the candidate
    // closest to the pointer is the last one written and therefore wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending_i[(int'(ptr_i) + i) % N_REQ]) begin
                idx_o   = REQ_W'((int'(ptr_i) + i) % N_REQ);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hash_arbiter.sv
// hash_arbiter
//   Shares one SHAKE hash core between N_REQ requesters. Start pulses are
//   latched into a pending register, the core is granted round-robin, the
//   owner's signals are routed to/from the core, and ownership ends on the
//   force_done / force_done_ack handshake.
//   Ports:
//     i_clk, i_rst            clock, synchronous active-high reset
//     i_req_*                 per-requester inputs (32-bit slice k = [32k+31:32k])
//     o_req_addr/o_req_data_out  broadcast from the core, ungated
//     o_req_rd_en/_data_out_valid/_force_done_ack  gated to the owner only
//     o_grant, o_busy         one-hot owner, core in use
//     o_hash_*/i_hash_*       hash core interface
//     o_dbg_state, o_dbg_pending  FSM state and pending register
//   Handshake: the owner holds i_req_force_done until the core answers with
//   i_hash_force_done_ack; that ack (only honoured in S_BUSY) ends ownership.
module hash_arbiter
    import hash_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 4,
    parameter int REQ_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req_start,
    input  logic [HASH_W*N_REQ-1:0] i_req_data_in,
    input  logic [32*N_REQ-1:0]     i_req_input_length,
    input  logic [32*N_REQ-1:0]     i_req_output_length,
    input  logic [N_REQ-1:0]        i_req_data_out_ready,
    input  logic [N_REQ-1:0]        i_req_force_done,
    output logic [ADDR_W-1:0]       o_req_addr,
    output logic [N_REQ-1:0]        o_req_rd_en,
    output logic [HASH_W-1:0]       o_req_data_out,
    output logic [N_REQ-1:0]        o_req_data_out_valid,
    output logic [N_REQ-1:0]        o_req_force_done_ack,
    output logic [N_REQ-1:0]        o_grant,
    output logic                    o_busy,
    output logic [HASH_W-1:0]       o_hash_data_in,
    input  logic [ADDR_W-1:0]       i_hash_addr,
    input  logic                    i_hash_rd_en,
    input  logic [HASH_W-1:0]       i_hash_data_out,
    input  logic                    i_hash_data_out_valid,
    output logic                    o_hash_data_out_ready,
    output logic [31:0]             o_hash_input_length,
    output logic [31:0]             o_hash_output_length,
    output logic                    o_hash_start,
    input  logic                    i_hash_force_done_ack,
    output logic                    o_hash_force_done,
    output logic [1:0]              o_dbg_state,
    output logic [N_REQ-1:0]        o_dbg_pending
);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic [REQ_W-1:0]   idx_q, idx_d;
    logic [REQ_W-1:0]   rr_q, rr_d;
    logic [REQ_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               owned;
    logic [N_REQ-1:0]   grant_oh;

    rr_pick #(
        .N_REQ (N_REQ),
        .REQ_W (REQ_W)
    ) u_rr_pick (
        .pending_i (pending_q),
        .ptr_i     (rr_q),
        .idx_o     (pick_idx),
        .valid_o   (pick_valid)
    );

    assign owned    = (state_q == S_START) || (state_q == S_BUSY);
    assign grant_oh = owned ? (N_REQ'(1) << idx_q) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            rr_q      <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        // A start from the current owner is dropped; everyone else is latched.
        pending_d = pending_q | (i_req_start & ~grant_oh);
        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    idx_d               = pick_idx;
                    pending_d[pick_idx] = 1'b0;
                    state_d             = S_START;
                end
            end
            S_START: state_d = S_BUSY;
            S_BUSY: begin
                if (i_hash_force_done_ack) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                rr_d    = (idx_q == REQ_W'(N_REQ - 1)) ? '0 : idx_q + REQ_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_hash_data_in        = '0;
        o_hash_input_length   = '0;
        o_hash_output_length  = '0;
        o_hash_data_out_ready = 1'b0;
        o_req_rd_en           = '0;
        o_req_data_out_valid  = '0;
        o_req_force_done_ack  = '0;
        if (owned) begin
            o_hash_data_in        = i_req_data_in[HASH_W*idx_q +: HASH_W];
            o_hash_input_length   = i_req_input_length[32*idx_q +: 32];
            o_hash_output_length  = i_req_output_length[32*idx_q +: 32];
            o_hash_data_out_ready = i_req_data_out_ready[idx_q];
            o_req_rd_en           = grant_oh & {N_REQ{i_hash_rd_en}};
            o_req_data_out_valid  = grant_oh & {N_REQ{i_hash_data_out_valid}};
            o_req_force_done_ack  = grant_oh & {N_REQ{i_hash_force_done_ack}};
        end
    end

    assign o_req_addr        = i_hash_addr;
    assign o_req_data_out    = i_hash_data_out;
    assign o_hash_start      = (state_q == S_START);
    assign o_hash_force_done = (state_q == S_BUSY) && i_req_force_done[idx_q];
    assign o_grant           = grant_oh;
    assign o_busy            = (state_q != S_IDLE);
    assign o_dbg_state       = state_q;
    assign o_dbg_pending     = pending_q;

endmodule

// File: tb/tb_hash_arbiter.sv
module tb_hash_arbiter;

    localparam int N      = 3;
    localparam int ADDR_W = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_start = '0;
    logic [32*N-1:0] req_data = '0;
    logic [32*N-1:0] req_ilen = '0;
    logic [32*N-1:0] req_olen = '0;
    logic [N-1:0]    req_ready = '0;
    logic [N-1:0]    req_fd = '0;
    logic [ADDR_W-1:0] hash_addr = '0;
    logic            hash_rd_en = 1'b0;
    logic [31:0]     hash_dout = '0;
    logic            hash_dv = 1'b0;
    logic            hash_ack = 1'b0;

    logic [ADDR_W-1:0] o_req_addr;
    logic [N-1:0]    o_req_rd_en, o_req_dv, o_req_ack, o_grant, o_pending;
    logic [31:0]     o_req_dout, o_hash_din, o_ilen, o_olen;
    logic            o_busy, o_hash_ready, o_hash_start, o_hash_fd;
    logic [1:0]      o_state;

    hash_arbiter #(.N_REQ(N), .ADDR_W(ADDR_W)) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_req_start           (req_start),
        .i_req_data_in         (req_data),
        .i_req_input_length    (req_ilen),
        .i_req_output_length   (req_olen),
        .i_req_data_out_ready  (req_ready),
        .i_req_force_done      (req_fd),
        .o_req_addr            (o_req_addr),
        .o_req_rd_en           (o_req_rd_en),
        .o_req_data_out        (o_req_dout),
        .o_req_data_out_valid  (o_req_dv),
        .o_req_force_done_ack  (o_req_ack),
        .o_grant               (o_grant),
        .o_busy                (o_busy),
        .o_hash_data_in        (o_hash_din),
        .i_hash_addr           (hash_addr),
        .i_hash_rd_en          (hash_rd_en),
        .i_hash_data_out       (hash_dout),
        .i_hash_data_out_valid (hash_dv),
        .o_hash_data_out_ready (o_hash_ready),
        .o_hash_input_length   (o_ilen),
        .o_hash_output_length  (o_olen),
        .o_hash_start          (o_hash_start),
        .i_hash_force_done_ack (hash_ack),
        .o_hash_force_done     (o_hash_fd),
        .o_dbg_state           (o_state),
        .o_dbg_pending         (o_pending)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;
    logic [N-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every core start pulse must match the next expected owner.
    always @(negedge clk) begin
        if (!rst && o_hash_start) begin
            start_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL grant_order: unexpected start with grant %b", o_grant);
            end else begin
                check("grant_order", 32'(o_grant), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        int          owner;
        logic        rd_en;
        logic        dv;
        logic [3:0]  addr;
        logic [31:0] dout;
        logic [N-1:0] exp_rd;
        logic [N-1:0] exp_dv;
    } vec_t;

    vec_t vt[8];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [N-1:0] mask);
        tick();
        req_start = mask;
        tick();
        req_start = '0;
    endtask

    task automatic wait_start(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (o_hash_start) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL wait_start: no start within %0d cycles", max_cycles);
    endtask

    // Called one step after entering S_BUSY; ends ownership of requester r.
    task automatic finish_owner(input int r, input logic repulse);
        req_fd[r] = 1'b1;
        @(negedge clk);
        check("fd_pass", 32'(o_hash_fd), 32'd1);
        hash_ack = 1'b1;
        #1;
        check("ack_route", 32'(o_req_ack), 32'(1 << r));
        tick();
        hash_ack  = 1'b0;
        req_fd[r] = 1'b0;
        if (repulse) req_start[r] = 1'b1;
        @(negedge clk);
        check("rel_grant", 32'(o_grant), 32'd0);
        check("rel_busy", 32'(o_busy), 32'd1);
        tick();
        req_start = '0;
        @(negedge clk);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_state", 32'(o_state), 32'd0);
    endtask

    task automatic apply_vectors(input int r);
        logic [N-1:0] rdy;
        logic [31:0]  d, len;
        for (int i = 0; i < 8; i++) begin
            if (vt[i].owner == r) begin
                rdy = N'($urandom_range(0, (1 << N) - 1));
                d   = $urandom;
                len = $urandom;
                req_ready          = rdy;
                req_data[32*r +: 32] = d;
                req_olen[32*r +: 32] = len;
                hash_rd_en = vt[i].rd_en;
                hash_dv    = vt[i].dv;
                hash_addr  = vt[i].addr;
                hash_dout  = vt[i].dout;
                @(negedge clk);
                check("rd_en_route", 32'(o_req_rd_en), 32'(vt[i].exp_rd));
                check("dv_route", 32'(o_req_dv), 32'(vt[i].exp_dv));
                check("addr_bcast", 32'(o_req_addr), 32'(vt[i].addr));
                check("dout_bcast", o_req_dout, vt[i].dout);
                check("ready_route", 32'(o_hash_ready), 32'(rdy[r]));
                check("din_route", o_hash_din, d);
                check("olen_route", o_olen, len);
                tick();
            end
        end
        hash_rd_en = 1'b0;
        hash_dv    = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int base;
        vt[0] = '{1, 1'b1, 1'b0, 4'h3, 32'hA5A5_0001, 3'b010, 3'b000};
        vt[1] = '{1, 1'b0, 1'b1, 4'h7, 32'h0BAD_F00D, 3'b000, 3'b010};
        vt[2] = '{1, 1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, 3'b010, 3'b010};
        vt[3] = '{1, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 3'b000, 3'b000};
        vt[4] = '{0, 1'b1, 1'b0, 4'h5, 32'h1234_5678, 3'b001, 3'b000};
        vt[5] = '{0, 1'b0, 1'b1, 4'hA, 32'hCAFE_0000, 3'b000, 3'b001};
        vt[6] = '{0, 1'b1, 1'b1, 4'h1, 32'h8000_0001, 3'b001, 3'b001};
        vt[7] = '{0, 1'b0, 1'b0, 4'hC, 32'h5555_AAAA, 3'b000, 3'b000};

        // Reset with active-looking inputs: everything gated must stay 0.
        req_data   = {$urandom, $urandom, $urandom};
        req_ilen   = {32'd256, 32'd512, 32'd1024};
        req_ready  = '1;
        hash_rd_en = 1'b1;
        hash_dv    = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_start", 32'(o_hash_start), 32'd0);
        check("rst_fd", 32'(o_hash_fd), 32'd0);
        check("rst_ready", 32'(o_hash_ready), 32'd0);
        check("rst_rd_en", 32'(o_req_rd_en), 32'd0);
        check("rst_dv", 32'(o_req_dv), 32'd0);
        check("rst_din", o_hash_din, 32'd0);
        check("rst_ilen", o_ilen, 32'd0);
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_pending", 32'(o_pending), 32'd0);
        hash_rd_en = 1'b0;
        hash_dv    = 1'b0;

        // Single request from requester 1, exact latency.
        exp_q.push_back(3'b010);
        pulse_start(3'b010);
        @(negedge clk);
        check("lat_pending", 32'(o_pending), 32'b010);
        check("lat_no_start", 32'(o_hash_start), 32'd0);
        @(negedge clk);
        check("lat_start", 32'(o_hash_start), 32'd1);
        check("start_ilen", o_ilen, 32'd512);
        check("start_pend_clr", 32'(o_pending), 32'd0);
        tick();
        apply_vectors(1);
        finish_owner(1, 1'b0);

        // Simultaneous starts from 0 and 1; rr pointer is 2, so 0 wins first.
        base = start_cnt;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        pulse_start(3'b011);
        wait_start(8);
        tick();
        req_data[31:0]  = 32'h1111_0000;
        req_data[63:32] = 32'hDEAD_BEEF;
        req_fd[1] = 1'b1;
        @(negedge clk);
        check("iso_din", o_hash_din, 32'h1111_0000);
        check("iso_fd", 32'(o_hash_fd), 32'd0);
        check("iso_grant", 32'(o_grant), 32'b001);
        tick();
        req_fd[1] = 1'b0;
        apply_vectors(0);
        finish_owner(0, 1'b0);
        wait_start(8);
        tick();
        finish_owner(1, 1'b0);
        repeat (4) @(negedge clk);
        check("simul_starts", 32'(start_cnt - base), 32'd2);

        // Stray ack while idle, then owner re-pulsing start while busy.
        tick();
        hash_ack = 1'b1;
        @(negedge clk);
        check("stray_ack", 32'(o_req_ack), 32'd0);
        tick();
        hash_ack = 1'b0;
        @(negedge clk);
        check("stray_state", 32'(o_state), 32'd0);
        base = start_cnt;
        exp_q.push_back(3'b100);
        pulse_start(3'b100);
        wait_start(8);
        tick();
        pulse_start(3'b100);
        @(negedge clk);
        check("own_restart", 32'(o_pending), 32'd0);
        tick();
        finish_owner(2, 1'b0);
        repeat (4) @(negedge clk);
        check("own_restart_cnt", 32'(start_cnt - base), 32'd1);

        // Reset in the middle of a transaction with another request pending.
        exp_q.push_back(3'b001);
        pulse_start(3'b001);
        wait_start(8);
        tick();
        pulse_start(3'b010);
        @(negedge clk);
        check("mid_pending", 32'(o_pending), 32'b010);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_state", 32'(o_state), 32'd0);
        check("mid_rst_pending", 32'(o_pending), 32'd0);
        check("mid_rst_grant", 32'(o_grant), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        exp_q.push_back(3'b010);
        pulse_start(3'b010);
        wait_start(8);
        tick();
        finish_owner(1, 1'b0);

        // Fairness: all three request, each re-requests on its release.
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) exp_q.push_back(N'(1 << (k % 3)));
        pulse_start(3'b111);
        for (int k = 0; k < 6; k++) begin
            wait_start(8);
            tick();
            finish_owner(k % 3, (k < 3) ? 1'b1 : 1'b0);
        end
        repeat (4) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        check("fair_pending", 32'(o_pending), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
